// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame opcodes, controller FSM encoding and default sizes.
// The slave side decodes the same opcode values.
package spi_pkg;

    localparam int DEFAULT_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_RX    = 3'd4,
        ST_STOP  = 3'd5
    } spi_state_e;

    // Opcode MSB selects read, LSB selects the second (data) frame.
    function automatic spi_op_e frame_op(input logic is_write, input logic second);
        logic [1:0] op;
        op = {~is_write, second};
        return spi_op_e'(op);
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bundle of the SPI initiator.
interface spi_master_ctrl_if import spi_pkg::*; #(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [ADDR_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [ADDR_SIZE-1:0] rsp_rdata;
    logic                 busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_master_shifter.sv
// Frame datapath: parallel-load TX shifter (MSB out first) and serial-in RX shifter.
// The final received bit is presented live on rx_next so the byte is complete on the last sampling edge.
module spi_master_shifter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_load,
    input  logic [ADDR_SIZE+1:0] tx_data,
    input  logic                 tx_shift,
    output logic                 tx_msb,
    input  logic                 rx_capture,
    input  logic                 rx_bit,
    output logic [ADDR_SIZE-1:0] rx_next
);
    logic [ADDR_SIZE+1:0] tx_q, tx_d;
    logic [ADDR_SIZE-2:0] rx_q, rx_d;

    assign tx_msb  = tx_q[ADDR_SIZE+1];
    assign rx_next = {rx_q, rx_bit};

    always_comb begin
        if (tx_load) begin
            tx_d = tx_data;
        end else if (tx_shift) begin
            tx_d = {tx_q[ADDR_SIZE:0], 1'b0};
        end else begin
            tx_d = tx_q;
        end
        if (rx_capture) begin
            rx_d = rx_next[ADDR_SIZE-2:0];
        end else begin
            rx_d = rx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns one host read/write request into the two-frame command
// sequence of the SPI RAM slave; ss_n and mosi come straight from flops.
module spi_master_ctrl import spi_pkg::*; #(
    parameter int ADDR_SIZE     = DEFAULT_ADDR_SIZE,
    parameter int GAP_CYCLES    = 2,
    parameter int RX_TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave host,
    output logic             ss_n,
    output logic             mosi,
    input  logic             miso
);
    localparam int CNT_W = $clog2(ADDR_SIZE + RX_TURNAROUND + 2) + 1;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_SIZE + 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_FIRST   = CNT_W'(RX_TURNAROUND);
    localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(RX_TURNAROUND + ADDR_SIZE - 1);

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 second_q, second_d;
    logic                 write_q, write_d;
    logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                 tx_load, tx_shift, tx_msb, rx_capture;
    logic [ADDR_SIZE+1:0] tx_data;
    logic [ADDR_SIZE-1:0] rx_next;

    spi_master_shifter #(.ADDR_SIZE(ADDR_SIZE)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .tx_shift   (tx_shift),
        .tx_msb     (tx_msb),
        .rx_capture (rx_capture),
        .rx_bit     (miso),
        .rx_next    (rx_next)
    );

    // Next-state and datapath control; the address travels only inside the TX shifter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        second_d    = second_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        tx_load     = 1'b0;
        tx_data     = '0;
        tx_shift    = 1'b0;
        rx_capture  = 1'b0;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    state_d  = ST_SETUP;
                    second_d = 1'b0;
                    write_d  = host.req_write;
                    wdata_d  = host.req_wdata;
                    tx_load  = 1'b1;
                    tx_data  = {frame_op(host.req_write, 1'b0), host.req_addr};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d  = ST_SHIFT;
                cnt_d    = '0;
                tx_shift = 1'b1;
                mosi_d   = tx_msb;
            end
            ST_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    tx_shift = 1'b1;
                    mosi_d   = tx_msb;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (second_q && !write_q) ? ST_RX : ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RX: begin
                rx_capture = (cnt_q >= RX_FIRST);
                if (cnt_q == RX_LAST) begin
                    state_d     = ST_STOP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (!second_q) begin
                    state_d  = ST_SETUP;
                    second_d = 1'b1;
                    tx_load  = 1'b1;
                    tx_data  = {frame_op(write_q, 1'b1), (write_q ? wdata_q : {ADDR_SIZE{1'b0}})};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ss_n_d      = (state_d == ST_IDLE) || (state_d == ST_STOP);
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = !req_ready_d;
    end

    // State and registered outputs; reset forces the pins idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            second_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            second_q    <= second_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ss_n           = ss_n_q;
    assign mosi           = mosi_q;
    assign host.req_ready = req_ready_q;
    assign host.busy      = busy_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI initiator that drives the existing SPI slave/single-port-RAM top: it generates ss_n and mosi and samples miso.
- Converts one host request (read or write, address, data) into the two-frame command sequence the slave expects.
  - Write: WR_ADDR frame, then WR_DATA frame.
  - Read: RD_ADDR frame, then RD_DATA frame, then the read byte is returned on a response pulse.
- Sits between the system/host logic and the SPI pins; shares the slave's clock (no SCLK generation).

Parameters:
- ADDR_SIZE, 8, width of address and data byte; frame payload = ADDR_SIZE+2 bits.
- GAP_CYCLES, 2, idle cycles with ss_n low after the last mosi bit (slave/RAM processing time).
- RX_TURNAROUND, 1, cycles between end of gap and the first valid miso bit in a RD_DATA frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  RAM address.
- req_wdata  in  ADDR_SIZE  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  ADDR_SIZE  read data; held until the next read completes.
- busy  out  1  transaction in progress (= !req_ready outside reset).
- ss_n  out  1  slave select, active low.
- mosi  out  1  serial data to slave, MSB first.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (async, immediate) values:
  - ss_n=1, mosi=0, req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
  - req_ready rises on the first clk edge after rst deasserts.
- Acceptance and capture:
  - A request is accepted on the edge where req_valid && req_ready.
  - On acceptance, req_addr/req_wdata/req_write are captured; req_ready drops on that same edge.
  - Later changes to the request inputs are ignored.
- Opcodes (first two bits, MSB first): WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
- Frame body: opcode, then ADDR_SIZE payload bits MSB first.
  - Payload is the address for *_ADDR frames, wdata for WR_DATA, and 0 (dummy) for RD_DATA.
- FSM states: IDLE, SETUP, SHIFT, GAP, RX, STOP.
  - IDLE: ss_n=1, req_ready=1. On accept -> SETUP with frame=first.
  - SETUP: ss_n=0, mosi=0 for 1 cycle -> SHIFT.
  - SHIFT: ADDR_SIZE+2 cycles, one mosi bit per cycle, updated on rising clk. Bit counter runs 0..ADDR_SIZE+1 -> GAP.
  - GAP: GAP_CYCLES cycles, ss_n=0, mosi=0. Then RX if frame is RD_DATA, else STOP.
  - RX: RX_TURNAROUND + ADDR_SIZE cycles. miso is sampled on the rising edge ending each of the last ADDR_SIZE cycles and shifted in MSB first -> STOP.
  - STOP: ss_n=1 for 1 cycle. If frame=first -> SETUP with frame=second. If frame=second -> IDLE. For a read, rsp_rdata is loaded and rsp_valid=1 during STOP of the second frame.
- Latency from accept to return to IDLE, with defaults:
  - Write: 2 x (1+10+2+1) = 28 cycles.
  - Read: 14 + (1+10+2+9+1) = 37 cycles.
- Boundary conditions:
  - ss_n is always high for at least 1 cycle between frames and between transactions.
  - A new request can be accepted the cycle after STOP (IDLE), giving back-to-back transactions with a 2-cycle ss_n-high minimum (STOP + IDLE).
  - req_valid while busy: not accepted; the request must be held by the host.
  - rst mid-frame: ss_n=1 and mosi=0 immediately; the transaction is dropped with no rsp_valid and rsp_rdata unchanged.
  - Bit counter and gap counter are sized $clog2(ADDR_SIZE+RX_TURNAROUND+2)+1 and must never wrap.
- Outputs ss_n and mosi are registered (glitch-free).

Decomposition:
- Shared package spi_pkg: opcode constants (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA), FSM state encoding, default ADDR_SIZE.
  - The slave side reuses the same opcodes.
- One sub-module: spi_master_shifter.
  - (ADDR_SIZE+2)-bit parallel-load/serial-out TX register.
  - ADDR_SIZE-bit serial-in/parallel-out RX register.
  - Load/shift/capture enables driven by the FSM.

Test Plan:
- Reset: rst=1 mid-run -> ss_n=1, mosi=0, rsp_valid=0 in the same cycle; req_ready=1 one cycle after release.
- Write addr=0x3C, wdata=0xA5 -> frame 1 mosi=0,0,0,0,1,1,1,1,0,0; frame 2 mosi=0,1,1,0,1,0,0,1,0,1; ss_n low 13 cycles per frame; ready again 28 cycles after accept.
- Read addr=0x3C with a miso model returning 0xA5 in RX cycles 2..9 -> RD_ADDR frame 1,0,00111100; RD_DATA frame 1,1,00000000; rsp_valid pulses once with rsp_rdata=0xA5 at cycle 37.
- Integration with the SPI slave/RAM top: write 0x5A to addr 0x10, then read addr 0x10 -> rsp_rdata=0x5A. Repeat 1000 random addr/data pairs against a scoreboard.
- Back-to-back: req_valid held high for write then read -> second accept exactly 1 cycle after the first STOP; ss_n high for 2 cycles between transactions.
- Reset asserted during a read's RX state -> no rsp_valid, rsp_rdata keeps its previous value, next read completes correctly.
